// File: rtl/dyn_phase_pkg.sv
// rtl/dyn_phase_pkg.sv - shared encodings, slot map and FSM states for the PLL phase-step responder
package dyn_phase_pkg;

  // PHASECOUNTERSELECT encodings; 7..15 are invalid
  localparam logic [3:0] SEL_ALL = 4'd0;
  localparam logic [3:0] SEL_M   = 4'd1;
  localparam logic [3:0] SEL_C0  = 4'd2;
  localparam logic [3:0] SEL_C1  = 4'd3;
  localparam logic [3:0] SEL_C2  = 4'd4;
  localparam logic [3:0] SEL_C3  = 4'd5;
  localparam logic [3:0] SEL_C4  = 4'd6;

  // offset slots: 0 = M, 1..5 = C0..C4
  localparam int N_SLOTS = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    BUSY = 2'd2
  } state_t;

  function automatic logic sel_is_valid(input logic [3:0] sel);
    return sel <= SEL_C4;
  endfunction

  // does a step with this select touch the given slot?
  function automatic logic slot_hit(input logic [3:0] sel, input int slot);
    if (slot == 0) return sel == SEL_M;
    return (sel == SEL_ALL) || (sel == 4'(slot + 1));
  endfunction

endpackage

// File: rtl/dyn_phase_ofs_acc.sv
// rtl/dyn_phase_ofs_acc.sv - one modular up/down phase offset accumulator
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-high reset, clears ofs
//   en   in   apply one step this cycle
//   up   in   1 = +1, 0 = -1 (both wrap modulo P_NSTEPS)
//   ofs  out  current offset, 0 .. P_NSTEPS-1
module dyn_phase_ofs_acc #(
  parameter  int P_NSTEPS = 8,
  localparam int W        = $clog2(P_NSTEPS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] ofs
);

  // compare against the top value instead of adding and taking a modulo,
  // so non-power-of-two step counts never need a wider intermediate
  localparam logic [W-1:0] MAXV = W'(P_NSTEPS - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ofs <= '0;
    end else if (en) begin
      if (up) ofs <= (ofs == MAXV) ? '0 : ofs + W'(1);
      else    ofs <= (ofs == '0)   ? MAXV : ofs - W'(1);
    end
  end

endmodule

// File: rtl/dyn_phase_pll_resp.sv
// rtl/dyn_phase_pll_resp.sv - loopback PLL responder for the dynamic phase-step handshake
// Optional error checking: define DYN_PHASE_PLL_RESP_ERRCHK_EN.
//   Defined:   short PHASESTEP pulses abort in QUAL with ERR_PROTO; ERR_SEL flags invalid selects.
//   Undefined: ERR_* are 0 and a single high sample is enough to start a step.
// Ports:
//   CLK50M              in   clock, rising edge
//   RESET               in   asynchronous active-high reset
//   PHASECOUNTERSELECT  in   0 all C0-C4, 1 M, 2..6 C0..C4, 7..15 invalid
//   PHASEUPDOWN         in   1 increment, 0 decrement
//   PHASESTEP           in   level step request, one step per rising edge
//   PHASEDONE           out  1 idle/ready, 0 step in progress
//   PHASE_OFS           out  packed offsets, slot0 = M, slots1..5 = C0..C4
//   STEP_CNT            out  completed steps, saturating
//   ERR_PROTO           out  pulse: short request or rising edge while busy
//   ERR_SEL             out  pulse: step completed with invalid select
module dyn_phase_pll_resp
  import dyn_phase_pkg::*;
#(
  parameter  int P_NSTEPS   = 8,
  parameter  int P_DONE_LAT = 4,
  parameter  int P_MIN_HOLD = 2,
  localparam int W          = $clog2(P_NSTEPS)
) (
  input  logic                 CLK50M,
  input  logic                 RESET,
  input  logic [3:0]           PHASECOUNTERSELECT,
  input  logic                 PHASEUPDOWN,
  input  logic                 PHASESTEP,
  output logic                 PHASEDONE,
  output logic [N_SLOTS*W-1:0] PHASE_OFS,
  output logic [15:0]          STEP_CNT,
  output logic                 ERR_PROTO,
  output logic                 ERR_SEL
);

`ifdef DYN_PHASE_PLL_RESP_ERRCHK_EN
  localparam bit ERRCHK   = 1'b1;
  localparam int HOLD_EFF = P_MIN_HOLD;
`else
  localparam bit ERRCHK   = 1'b0;
  localparam int HOLD_EFF = 1;
`endif

  localparam int HW = $clog2(P_MIN_HOLD + 1);
  localparam int LW = $clog2(P_DONE_LAT + 1);

  // input registers and rising-edge history
  logic       step_r, step_prev, up_in_r;
  logic [3:0] sel_in_r;

  // FSM state and its companions
  state_t         state, state_nx;
  logic [HW-1:0]  hold_cnt, hold_nx;
  logic [LW-1:0]  lat_cnt, lat_nx;
  logic [3:0]     sel_lat, sel_nx;
  logic           up_lat, up_nx;
  logic           done_q, done_nx;
  logic           proto_q, proto_nx;
  logic           sel_err_q, sel_err_nx;
  logic           apply;
  logic [15:0]    step_cnt_q;
  logic           rise;

  assign rise = step_r & ~step_prev;

  always_ff @(posedge CLK50M or posedge RESET) begin
    if (RESET) begin
      step_r    <= 1'b0;
      step_prev <= 1'b0;
      sel_in_r  <= '0;
      up_in_r   <= 1'b0;
    end else begin
      step_r    <= PHASESTEP;
      step_prev <= step_r;
      sel_in_r  <= PHASECOUNTERSELECT;
      up_in_r   <= PHASEUPDOWN;
    end
  end

  always_ff @(posedge CLK50M or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      lat_cnt    <= '0;
      sel_lat    <= '0;
      up_lat     <= 1'b0;
      done_q     <= 1'b1;
      proto_q    <= 1'b0;
      sel_err_q  <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      state     <= state_nx;
      hold_cnt  <= hold_nx;
      lat_cnt   <= lat_nx;
      sel_lat   <= sel_nx;
      up_lat    <= up_nx;
      done_q    <= done_nx;
      proto_q   <= proto_nx;
      sel_err_q <= sel_err_nx;
      if (apply && step_cnt_q != 16'hFFFF) step_cnt_q <= step_cnt_q + 16'd1;
    end
  end

  always_comb begin
    state_nx   = state;
    hold_nx    = hold_cnt;
    lat_nx     = lat_cnt;
    sel_nx     = sel_lat;
    up_nx      = up_lat;
    done_nx    = done_q;
    proto_nx   = 1'b0;
    sel_err_nx = 1'b0;
    apply      = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          // select/direction are frozen here; later input changes are ignored
          sel_nx = sel_in_r;
          up_nx  = up_in_r;
          if (HOLD_EFF == 1) begin
            state_nx = BUSY;
            lat_nx   = LW'(P_DONE_LAT);
            done_nx  = 1'b0;
          end else begin
            state_nx = QUAL;
            hold_nx  = HW'(1);
          end
        end
      end
      QUAL: begin
        if (!step_r) begin
          state_nx = IDLE;
          proto_nx = ERRCHK;
        end else if (hold_cnt == HW'(HOLD_EFF - 1)) begin
          state_nx = BUSY;
          lat_nx   = LW'(P_DONE_LAT);
          done_nx  = 1'b0;
        end else begin
          hold_nx = hold_cnt + HW'(1);
        end
      end
      BUSY: begin
        // a fresh request while busy is flagged but never queued
        proto_nx = ERRCHK & rise;
        if (lat_cnt == '0) begin
          state_nx   = IDLE;
          done_nx    = 1'b1;
          apply      = 1'b1;
          sel_err_nx = ERRCHK & ~sel_is_valid(sel_lat);
        end else begin
          lat_nx = lat_cnt - LW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
    endcase
  end

  // invalid selects hit no slot, so they fall through as offset no-ops
  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    dyn_phase_ofs_acc #(.P_NSTEPS(P_NSTEPS)) u_acc (
      .clk (CLK50M),
      .rst (RESET),
      .en  (apply & slot_hit(sel_lat, g)),
      .up  (up_lat),
      .ofs (PHASE_OFS[g*W +: W])
    );
  end

  assign PHASEDONE = done_q;
  assign STEP_CNT  = step_cnt_q;
  assign ERR_PROTO = proto_q;
  assign ERR_SEL   = sel_err_q;

endmodule

// File: tb/tb_dyn_phase_pll_resp.sv
// tb/tb_dyn_phase_pll_resp.sv - self-checking bench for dyn_phase_pll_resp
module tb_dyn_phase_pll_resp;

  localparam int NSTEPS = 8;
  localparam int LAT    = 4;
  localparam int HOLD   = 2;
  localparam int W      = 3;
  localparam int NS     = 6;
`ifdef DYN_PHASE_PLL_RESP_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif
  localparam int HOLD_EFF = ERRCHK ? HOLD : 1;

  logic              CLK50M, RESET, PHASEUPDOWN, PHASESTEP;
  logic [3:0]        PHASECOUNTERSELECT;
  logic              PHASEDONE, ERR_PROTO, ERR_SEL;
  logic [NS*W-1:0]   PHASE_OFS;
  logic [15:0]       STEP_CNT;

  dyn_phase_pll_resp #(.P_NSTEPS(NSTEPS), .P_DONE_LAT(LAT), .P_MIN_HOLD(HOLD)) dut (
    .CLK50M             (CLK50M),
    .RESET              (RESET),
    .PHASECOUNTERSELECT (PHASECOUNTERSELECT),
    .PHASEUPDOWN        (PHASEUPDOWN),
    .PHASESTEP          (PHASESTEP),
    .PHASEDONE          (PHASEDONE),
    .PHASE_OFS          (PHASE_OFS),
    .STEP_CNT           (STEP_CNT),
    .ERR_PROTO          (ERR_PROTO),
    .ERR_SEL            (ERR_SEL)
  );

  initial CLK50M = 1'b0;
  always #10 CLK50M = ~CLK50M;

  int checks = 0;
  int failures = 0;

  // running totals observed on the falling edge
  int low_total = 0, ep_total = 0, es_total = 0;
  always @(negedge CLK50M) begin
    if (!RESET) begin
      if (!PHASEDONE) low_total <= low_total + 1;
      if (ERR_PROTO)  ep_total  <= ep_total + 1;
      if (ERR_SEL)    es_total  <= es_total + 1;
    end
  end

  // reference model: offsets per slot and completed-step count
  int m_ofs[NS];
  int m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_pack();
    logic [31:0] r = '0;
    for (int i = 0; i < NS; i++) r[i*W +: W] = m_ofs[i][W-1:0];
    return r;
  endfunction

  task automatic bump(input int i, input bit up);
    m_ofs[i] = up ? (m_ofs[i] + 1) % NSTEPS : (m_ofs[i] + NSTEPS - 1) % NSTEPS;
  endtask

  task automatic model_apply(input int sel, input bit up);
    if (sel == 1) bump(0, up);
    else if (sel >= 2 && sel <= 6) bump(sel - 1, up);
    else if (sel == 0) for (int i = 1; i < NS; i++) bump(i, up);
    if (m_cnt < 65535) m_cnt++;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NS; i++) m_ofs[i] = 0;
    m_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK50M);
    RESET = 1'b1;
    PHASESTEP = 1'b0;
    model_clear();
    repeat (2) @(negedge CLK50M);
    RESET = 1'b0;
    repeat (2) @(negedge CLK50M);
  endtask

  // one request: PHASESTEP high for len samples, optional second edge while busy
  task automatic do_step(input string tag, input int sel, input bit up, input int len, input bit rebump);
    int l0, e0, s0;
    bit accepted;
    l0 = low_total; e0 = ep_total; s0 = es_total;
    @(negedge CLK50M);
    PHASECOUNTERSELECT = 4'(sel);
    PHASEUPDOWN = up;
    PHASESTEP = 1'b1;
    for (int i = 1; i < len; i++) begin
      @(negedge CLK50M);
      if (i == 2) begin
        PHASECOUNTERSELECT = 4'($urandom_range(0, 15));
        PHASEUPDOWN = 1'($urandom);
      end
    end
    @(negedge CLK50M);
    PHASESTEP = 1'b0;
    if (rebump) begin
      @(negedge CLK50M);
      PHASESTEP = 1'b1;
      repeat (2) @(negedge CLK50M);
      PHASESTEP = 1'b0;
    end
    repeat (14) @(negedge CLK50M);
    accepted = (len >= HOLD_EFF);
    if (accepted) model_apply(sel, up);
    check({tag, ".ofs"}, 32'(PHASE_OFS), model_pack());
    check({tag, ".cnt"}, 32'(STEP_CNT), 32'(m_cnt));
    check({tag, ".low"}, 32'(low_total - l0), accepted ? 32'(LAT + 1) : 32'd0);
    check({tag, ".eproto"}, 32'(ep_total - e0), (ERRCHK && (!accepted || rebump)) ? 32'd1 : 32'd0);
    check({tag, ".esel"}, 32'(es_total - s0), (ERRCHK && accepted && sel > 6) ? 32'd1 : 32'd0);
    check({tag, ".done"}, 32'(PHASEDONE), 32'd1);
  endtask

  initial begin
    RESET = 1'b1;
    PHASESTEP = 1'b0;
    PHASEUPDOWN = 1'b0;
    PHASECOUNTERSELECT = 4'd0;
    model_clear();
    repeat (3) @(negedge CLK50M);
    check("rst.done", 32'(PHASEDONE), 32'd1);
    check("rst.ofs", 32'(PHASE_OFS), 32'd0);
    check("rst.cnt", 32'(STEP_CNT), 32'd0);
    check("rst.err", {30'd0, ERR_PROTO, ERR_SEL}, 32'd0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK50M);

    do_step("t1", 2, 1'b1, 3, 1'b0);
    check("t1.slot1", 32'(PHASE_OFS[1*W +: W]), 32'd1);

    do_reset();
    do_step("t2dn", 0, 1'b0, 3, 1'b0);
    check("t2.slot5", 32'(PHASE_OFS[5*W +: W]), 32'd7);
    check("t2.slot0", 32'(PHASE_OFS[0 +: W]), 32'd0);
    do_step("t2up", 0, 1'b1, 3, 1'b0);

    do_step("t3short", 2, 1'b1, 1, 1'b0);
    do_step("t4badsel", 9, 1'b1, 3, 1'b0);
    do_step("t5rebump", 3, 1'b0, 3, 1'b1);
    do_step("t5hold20", 4, 1'b1, 20, 1'b0);
    do_step("wrapup", 1, 1'b0, 2, 1'b0);

    for (int n = 0; n < 30; n++) begin
      int sel, len;
      bit up;
      sel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(7, 15)) : int'($urandom_range(0, 6));
      up  = 1'($urandom);
      len = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(1, 4));
      do_step($sformatf("rnd%0d", n), sel, up, len, 1'b0);
    end

    // reset two cycles into BUSY aborts the step
    @(negedge CLK50M);
    PHASECOUNTERSELECT = 4'd0;
    PHASEUPDOWN = 1'b1;
    PHASESTEP = 1'b1;
    repeat (5) @(negedge CLK50M);
    check("t6.busy", 32'(PHASEDONE), 32'd0);
    #2 RESET = 1'b1;
    model_clear();
    #1;
    check("t6.done_async", 32'(PHASEDONE), 32'd1);
    check("t6.ofs", 32'(PHASE_OFS), model_pack());
    check("t6.cnt", 32'(STEP_CNT), 32'd0);
    PHASESTEP = 1'b0;
    repeat (2) @(negedge CLK50M);
    RESET = 1'b0;
    repeat (2) @(negedge CLK50M);
    do_step("t6after", 2, 1'b1, 3, 1'b0);
    check("t6.slot1", 32'(PHASE_OFS[1*W +: W]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
